// File: rtl/sbox_lut.sv
// ============================================================================
// Module   : sbox_lut
// Purpose  : AES forward S-box lookup with a combinational output and a
//            one-cycle registered copy tagged with a valid bit.
//            Optional macro SBOX_PARITY_EN adds a registered even-parity bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sbox_lut (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] byte_i,
   input  logic       in_valid_i,
   output logic [7:0] sbyte_o,
   output logic [7:0] sbyte_q_o,
`ifdef SBOX_PARITY_EN
   output logic       sbyte_par_o,
`endif
   output logic       out_valid_o
);

   logic [7:0] w_sbyte;
   logic [7:0] sbyte_d, sbyte_q;
   logic       valid_d, valid_q;

   // Full explicit table; the leading assignment only keeps synthesis from
   // seeing a latch path and is never selected.
   always_comb begin
      w_sbyte = 8'h00;
      case (byte_i)
         8'h00: w_sbyte = 8'h63; 8'h01: w_sbyte = 8'h7c; 8'h02: w_sbyte = 8'h77; 8'h03: w_sbyte = 8'h7b; 8'h04: w_sbyte = 8'hf2; 8'h05: w_sbyte = 8'h6b; 8'h06: w_sbyte = 8'h6f; 8'h07: w_sbyte = 8'hc5;
         8'h08: w_sbyte = 8'h30; 8'h09: w_sbyte = 8'h01; 8'h0a: w_sbyte = 8'h67; 8'h0b: w_sbyte = 8'h2b; 8'h0c: w_sbyte = 8'hfe; 8'h0d: w_sbyte = 8'hd7; 8'h0e: w_sbyte = 8'hab; 8'h0f: w_sbyte = 8'h76;
         8'h10: w_sbyte = 8'hca; 8'h11: w_sbyte = 8'h82; 8'h12: w_sbyte = 8'hc9; 8'h13: w_sbyte = 8'h7d; 8'h14: w_sbyte = 8'hfa; 8'h15: w_sbyte = 8'h59; 8'h16: w_sbyte = 8'h47; 8'h17: w_sbyte = 8'hf0;
         8'h18: w_sbyte = 8'had; 8'h19: w_sbyte = 8'hd4; 8'h1a: w_sbyte = 8'ha2; 8'h1b: w_sbyte = 8'haf; 8'h1c: w_sbyte = 8'h9c; 8'h1d: w_sbyte = 8'ha4; 8'h1e: w_sbyte = 8'h72; 8'h1f: w_sbyte = 8'hc0;
         8'h20: w_sbyte = 8'hb7; 8'h21: w_sbyte = 8'hfd; 8'h22: w_sbyte = 8'h93; 8'h23: w_sbyte = 8'h26; 8'h24: w_sbyte = 8'h36; 8'h25: w_sbyte = 8'h3f; 8'h26: w_sbyte = 8'hf7; 8'h27: w_sbyte = 8'hcc;
         8'h28: w_sbyte = 8'h34; 8'h29: w_sbyte = 8'ha5; 8'h2a: w_sbyte = 8'he5; 8'h2b: w_sbyte = 8'hf1; 8'h2c: w_sbyte = 8'h71; 8'h2d: w_sbyte = 8'hd8; 8'h2e: w_sbyte = 8'h31; 8'h2f: w_sbyte = 8'h15;
         8'h30: w_sbyte = 8'h04; 8'h31: w_sbyte = 8'hc7; 8'h32: w_sbyte = 8'h23; 8'h33: w_sbyte = 8'hc3; 8'h34: w_sbyte = 8'h18; 8'h35: w_sbyte = 8'h96; 8'h36: w_sbyte = 8'h05; 8'h37: w_sbyte = 8'h9a;
         8'h38: w_sbyte = 8'h07; 8'h39: w_sbyte = 8'h12; 8'h3a: w_sbyte = 8'h80; 8'h3b: w_sbyte = 8'he2; 8'h3c: w_sbyte = 8'heb; 8'h3d: w_sbyte = 8'h27; 8'h3e: w_sbyte = 8'hb2; 8'h3f: w_sbyte = 8'h75;
         8'h40: w_sbyte = 8'h09; 8'h41: w_sbyte = 8'h83; 8'h42: w_sbyte = 8'h2c; 8'h43: w_sbyte = 8'h1a; 8'h44: w_sbyte = 8'h1b; 8'h45: w_sbyte = 8'h6e; 8'h46: w_sbyte = 8'h5a; 8'h47: w_sbyte = 8'ha0;
         8'h48: w_sbyte = 8'h52; 8'h49: w_sbyte = 8'h3b; 8'h4a: w_sbyte = 8'hd6; 8'h4b: w_sbyte = 8'hb3; 8'h4c: w_sbyte = 8'h29; 8'h4d: w_sbyte = 8'he3; 8'h4e: w_sbyte = 8'h2f; 8'h4f: w_sbyte = 8'h84;
         8'h50: w_sbyte = 8'h53; 8'h51: w_sbyte = 8'hd1; 8'h52: w_sbyte = 8'h00; 8'h53: w_sbyte = 8'hed; 8'h54: w_sbyte = 8'h20; 8'h55: w_sbyte = 8'hfc; 8'h56: w_sbyte = 8'hb1; 8'h57: w_sbyte = 8'h5b;
         8'h58: w_sbyte = 8'h6a; 8'h59: w_sbyte = 8'hcb; 8'h5a: w_sbyte = 8'hbe; 8'h5b: w_sbyte = 8'h39; 8'h5c: w_sbyte = 8'h4a; 8'h5d: w_sbyte = 8'h4c; 8'h5e: w_sbyte = 8'h58; 8'h5f: w_sbyte = 8'hcf;
         8'h60: w_sbyte = 8'hd0; 8'h61: w_sbyte = 8'hef; 8'h62: w_sbyte = 8'haa; 8'h63: w_sbyte = 8'hfb; 8'h64: w_sbyte = 8'h43; 8'h65: w_sbyte = 8'h4d; 8'h66: w_sbyte = 8'h33; 8'h67: w_sbyte = 8'h85;
         8'h68: w_sbyte = 8'h45; 8'h69: w_sbyte = 8'hf9; 8'h6a: w_sbyte = 8'h02; 8'h6b: w_sbyte = 8'h7f; 8'h6c: w_sbyte = 8'h50; 8'h6d: w_sbyte = 8'h3c; 8'h6e: w_sbyte = 8'h9f; 8'h6f: w_sbyte = 8'ha8;
         8'h70: w_sbyte = 8'h51; 8'h71: w_sbyte = 8'ha3; 8'h72: w_sbyte = 8'h40; 8'h73: w_sbyte = 8'h8f; 8'h74: w_sbyte = 8'h92; 8'h75: w_sbyte = 8'h9d; 8'h76: w_sbyte = 8'h38; 8'h77: w_sbyte = 8'hf5;
         8'h78: w_sbyte = 8'hbc; 8'h79: w_sbyte = 8'hb6; 8'h7a: w_sbyte = 8'hda; 8'h7b: w_sbyte = 8'h21; 8'h7c: w_sbyte = 8'h10; 8'h7d: w_sbyte = 8'hff; 8'h7e: w_sbyte = 8'hf3; 8'h7f: w_sbyte = 8'hd2;
         8'h80: w_sbyte = 8'hcd; 8'h81: w_sbyte = 8'h0c; 8'h82: w_sbyte = 8'h13; 8'h83: w_sbyte = 8'hec; 8'h84: w_sbyte = 8'h5f; 8'h85: w_sbyte = 8'h97; 8'h86: w_sbyte = 8'h44; 8'h87: w_sbyte = 8'h17;
         8'h88: w_sbyte = 8'hc4; 8'h89: w_sbyte = 8'ha7; 8'h8a: w_sbyte = 8'h7e; 8'h8b: w_sbyte = 8'h3d; 8'h8c: w_sbyte = 8'h64; 8'h8d: w_sbyte = 8'h5d; 8'h8e: w_sbyte = 8'h19; 8'h8f: w_sbyte = 8'h73;
         8'h90: w_sbyte = 8'h60; 8'h91: w_sbyte = 8'h81; 8'h92: w_sbyte = 8'h4f; 8'h93: w_sbyte = 8'hdc; 8'h94: w_sbyte = 8'h22; 8'h95: w_sbyte = 8'h2a; 8'h96: w_sbyte = 8'h90; 8'h97: w_sbyte = 8'h88;
         8'h98: w_sbyte = 8'h46; 8'h99: w_sbyte = 8'hee; 8'h9a: w_sbyte = 8'hb8; 8'h9b: w_sbyte = 8'h14; 8'h9c: w_sbyte = 8'hde; 8'h9d: w_sbyte = 8'h5e; 8'h9e: w_sbyte = 8'h0b; 8'h9f: w_sbyte = 8'hdb;
         8'ha0: w_sbyte = 8'he0; 8'ha1: w_sbyte = 8'h32; 8'ha2: w_sbyte = 8'h3a; 8'ha3: w_sbyte = 8'h0a; 8'ha4: w_sbyte = 8'h49; 8'ha5: w_sbyte = 8'h06; 8'ha6: w_sbyte = 8'h24; 8'ha7: w_sbyte = 8'h5c;
         8'ha8: w_sbyte = 8'hc2; 8'ha9: w_sbyte = 8'hd3; 8'haa: w_sbyte = 8'hac; 8'hab: w_sbyte = 8'h62; 8'hac: w_sbyte = 8'h91; 8'had: w_sbyte = 8'h95; 8'hae: w_sbyte = 8'he4; 8'haf: w_sbyte = 8'h79;
         8'hb0: w_sbyte = 8'he7; 8'hb1: w_sbyte = 8'hc8; 8'hb2: w_sbyte = 8'h37; 8'hb3: w_sbyte = 8'h6d; 8'hb4: w_sbyte = 8'h8d; 8'hb5: w_sbyte = 8'hd5; 8'hb6: w_sbyte = 8'h4e; 8'hb7: w_sbyte = 8'ha9;
         8'hb8: w_sbyte = 8'h6c; 8'hb9: w_sbyte = 8'h56; 8'hba: w_sbyte = 8'hf4; 8'hbb: w_sbyte = 8'hea; 8'hbc: w_sbyte = 8'h65; 8'hbd: w_sbyte = 8'h7a; 8'hbe: w_sbyte = 8'hae; 8'hbf: w_sbyte = 8'h08;
         8'hc0: w_sbyte = 8'hba; 8'hc1: w_sbyte = 8'h78; 8'hc2: w_sbyte = 8'h25; 8'hc3: w_sbyte = 8'h2e; 8'hc4: w_sbyte = 8'h1c; 8'hc5: w_sbyte = 8'ha6; 8'hc6: w_sbyte = 8'hb4; 8'hc7: w_sbyte = 8'hc6;
         8'hc8: w_sbyte = 8'he8; 8'hc9: w_sbyte = 8'hdd; 8'hca: w_sbyte = 8'h74; 8'hcb: w_sbyte = 8'h1f; 8'hcc: w_sbyte = 8'h4b; 8'hcd: w_sbyte = 8'hbd; 8'hce: w_sbyte = 8'h8b; 8'hcf: w_sbyte = 8'h8a;
         8'hd0: w_sbyte = 8'h70; 8'hd1: w_sbyte = 8'h3e; 8'hd2: w_sbyte = 8'hb5; 8'hd3: w_sbyte = 8'h66; 8'hd4: w_sbyte = 8'h48; 8'hd5: w_sbyte = 8'h03; 8'hd6: w_sbyte = 8'hf6; 8'hd7: w_sbyte = 8'h0e;
         8'hd8: w_sbyte = 8'h61; 8'hd9: w_sbyte = 8'h35; 8'hda: w_sbyte = 8'h57; 8'hdb: w_sbyte = 8'hb9; 8'hdc: w_sbyte = 8'h86; 8'hdd: w_sbyte = 8'hc1; 8'hde: w_sbyte = 8'h1d; 8'hdf: w_sbyte = 8'h9e;
         8'he0: w_sbyte = 8'he1; 8'he1: w_sbyte = 8'hf8; 8'he2: w_sbyte = 8'h98; 8'he3: w_sbyte = 8'h11; 8'he4: w_sbyte = 8'h69; 8'he5: w_sbyte = 8'hd9; 8'he6: w_sbyte = 8'h8e; 8'he7: w_sbyte = 8'h94;
         8'he8: w_sbyte = 8'h9b; 8'he9: w_sbyte = 8'h1e; 8'hea: w_sbyte = 8'h87; 8'heb: w_sbyte = 8'he9; 8'hec: w_sbyte = 8'hce; 8'hed: w_sbyte = 8'h55; 8'hee: w_sbyte = 8'h28; 8'hef: w_sbyte = 8'hdf;
         8'hf0: w_sbyte = 8'h8c; 8'hf1: w_sbyte = 8'ha1; 8'hf2: w_sbyte = 8'h89; 8'hf3: w_sbyte = 8'h0d; 8'hf4: w_sbyte = 8'hbf; 8'hf5: w_sbyte = 8'he6; 8'hf6: w_sbyte = 8'h42; 8'hf7: w_sbyte = 8'h68;
         8'hf8: w_sbyte = 8'h41; 8'hf9: w_sbyte = 8'h99; 8'hfa: w_sbyte = 8'h2d; 8'hfb: w_sbyte = 8'h0f; 8'hfc: w_sbyte = 8'hb0; 8'hfd: w_sbyte = 8'h54; 8'hfe: w_sbyte = 8'hbb; 8'hff: w_sbyte = 8'h16;
      endcase
   end

   assign sbyte_o = w_sbyte;

   always_comb begin
      sbyte_d = in_valid_i ? w_sbyte : sbyte_q;
      valid_d = in_valid_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sbyte_q <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         sbyte_q <= sbyte_d;
         valid_q <= valid_d;
      end
   end

   assign sbyte_q_o   = sbyte_q;
   assign out_valid_o = valid_q;

`ifdef SBOX_PARITY_EN
   logic par_d, par_q;

   // Parity taken from the table output so it tracks sbyte_q exactly.
   always_comb begin
      par_d = in_valid_i ? (^w_sbyte) : par_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign sbyte_par_o = par_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sbox_lut.sv
// Testbench for sbox_lut: directed vectors, exhaustive sweep against a
// GF(2^8) inverse + affine model, and registered-path sequences.
`default_nettype none

module tb_sbox_lut;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] byte_i;
   logic       in_valid_i;
   logic [7:0] sbyte_o;
   logic [7:0] sbyte_q_o;
   logic       out_valid_o;
`ifdef SBOX_PARITY_EN
   logic       sbyte_par_o;
`endif

   int checks = 0;
   int errors = 0;

   sbox_lut dut (
      .clk         (clk),
      .reset       (reset),
      .byte_i      (byte_i),
      .in_valid_i  (in_valid_i),
      .sbyte_o     (sbyte_o),
      .sbyte_q_o   (sbyte_q_o),
`ifdef SBOX_PARITY_EN
      .sbyte_par_o (sbyte_par_o),
`endif
      .out_valid_o (out_valid_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) r = r ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return r;
   endfunction

   // S(x) = affine(x^254); x^254 is the multiplicative inverse, 0 maps to 0.
   function automatic logic [7:0] model_sbox(input logic [7:0] a);
      logic [7:0] inv = 8'h01;
      logic [7:0] b;
      for (int k = 0; k < 254; k++) inv = gmul(inv, a);
      b = inv;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[7];
   bit   seen[256];
   int   dup_cnt;
   int   fix_cnt;

   initial begin
      vecs[0] = '{din: 8'h00, exp: 8'h63};
      vecs[1] = '{din: 8'hFF, exp: 8'h16};
      vecs[2] = '{din: 8'hAA, exp: 8'hAC};
      vecs[3] = '{din: 8'hAA, exp: 8'hAC};
      vecs[4] = '{din: 8'hF0, exp: 8'h8C};
      vecs[5] = '{din: 8'h0F, exp: 8'h76};
      vecs[6] = '{din: 8'h53, exp: 8'hED};

      reset      = 1'b1;
      in_valid_i = 1'b0;
      byte_i     = 8'h00;
      step();
      step();
      check8("reset_sbyte_q", sbyte_q_o, 8'h00);
      check1("reset_out_valid", out_valid_o, 1'b0);
`ifdef SBOX_PARITY_EN
      check1("reset_par", sbyte_par_o, 1'b0);
`endif

      for (int i = 0; i < 7; i++) begin
         byte_i = vecs[i].din;
         #1;
         check8($sformatf("comb_%02h", vecs[i].din), sbyte_o, vecs[i].exp);
      end

      dup_cnt = 0;
      fix_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = i[7:0];
         byte_i = v;
         #1;
         check8($sformatf("sweep_%02h", v), sbyte_o, model_sbox(v));
         if (seen[sbyte_o]) dup_cnt++;
         seen[sbyte_o] = 1'b1;
         if (sbyte_o == v || sbyte_o == ~v) fix_cnt++;
      end
      checks++;
      if (dup_cnt != 0) begin
         errors++;
         $display("FAIL bijection: duplicates %0d expected 0", dup_cnt);
      end
      checks++;
      if (fix_cnt != 0) begin
         errors++;
         $display("FAIL fixed_points: count %0d expected 0", fix_cnt);
      end

      // Reset dominates in_valid, then release.
      reset = 1'b1; in_valid_i = 1'b1; byte_i = 8'h01;
      step();
      check8("rst_dom_q", sbyte_q_o, 8'h00);
      check1("rst_dom_v", out_valid_o, 1'b0);
      reset = 1'b0;
      step();
      check8("rel_q", sbyte_q_o, 8'h7C);
      check1("rel_v", out_valid_o, 1'b1);

      // Pulses 1,0,1.
      in_valid_i = 1'b1; byte_i = 8'h10;
      step();
      check8("pulse1_q", sbyte_q_o, 8'hCA);
      check1("pulse1_v", out_valid_o, 1'b1);
      in_valid_i = 1'b0; byte_i = 8'h20;
      step();
      check8("pulse0_q", sbyte_q_o, 8'hCA);
      check1("pulse0_v", out_valid_o, 1'b0);
      in_valid_i = 1'b1; byte_i = 8'h30;
      step();
      check8("pulse2_q", sbyte_q_o, 8'h04);
      check1("pulse2_v", out_valid_o, 1'b1);

      // Back-to-back with parity.
      byte_i = 8'h00;
      step();
      check8("b2b0_q", sbyte_q_o, 8'h63);
      check1("b2b0_v", out_valid_o, 1'b1);
`ifdef SBOX_PARITY_EN
      check1("par_63", sbyte_par_o, 1'b0);
`endif
      byte_i = 8'hF0;
      step();
      check8("b2b1_q", sbyte_q_o, 8'h8C);
      check1("b2b1_v", out_valid_o, 1'b1);
`ifdef SBOX_PARITY_EN
      check1("par_8c", sbyte_par_o, 1'b1);
`endif

      // Mid-stream reset drops in-flight result.
      byte_i = 8'h53; reset = 1'b1;
      step();
      check8("mid_rst_q", sbyte_q_o, 8'h00);
      check1("mid_rst_v", out_valid_o, 1'b0);
`ifdef SBOX_PARITY_EN
      check1("mid_rst_par", sbyte_par_o, 1'b0);
`endif
      reset = 1'b0; in_valid_i = 1'b0;
      step();
      check1("idle_v", out_valid_o, 1'b0);
      in_valid_i = 1'b1; byte_i = 8'h53;
      step();
      check8("after_rst_q", sbyte_q_o, 8'hED);
      check1("after_rst_v", out_valid_o, 1'b1);
      in_valid_i = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
